// File: rtl/pipe_stage_skid.sv
// Valid/ready stage register with a 2-entry skid and synchronous flush-to-bubble; PIPE_STAGE_SKID_STATS_EN adds stall/flush counters.
// Latency 1 cycle, 1 beat/cycle; in_ready comes only from the state register and drops while both entries are held.
module pipe_stage_skid #(
   parameter int                DATA_W = 64,
   parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_SKID_STATS_EN
   ,
   parameter int                STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
`ifdef PIPE_STAGE_SKID_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              w_in_fire;
   logic              w_out_fire;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: begin
            if (w_in_fire) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
            else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
         end
         S_FULL: begin
            if (w_out_fire) w_state_nxt = S_BUSY;
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // Handshake outputs decode the state register only: no path from out_ready to in_ready.
   always_comb begin
      out_valid = (r_state != S_EMPTY);
      in_ready  = (r_state != S_FULL);
   end

   // Vacated entries are reloaded with BUBBLE so out_data shows the NOP whenever empty.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_main <= BUBBLE;
         r_skid <= BUBBLE;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) r_main <= in_data;
            end
            S_BUSY: begin
               if (w_in_fire && w_out_fire) r_main <= in_data;
               else if (w_in_fire)          r_skid <= in_data;
               else if (w_out_fire)         r_main <= BUBBLE;
            end
            S_FULL: begin
               if (w_out_fire) begin
                  r_main <= r_skid;
                  r_skid <= BUBBLE;
               end
            end
            default: begin
               r_main <= BUBBLE;
               r_skid <= BUBBLE;
            end
         endcase
      end
   end

   assign out_data = r_main;

`ifdef PIPE_STAGE_SKID_STATS_EN
   logic [STAT_W-1:0] r_stall_cnt;
   logic [STAT_W-1:0] r_flush_cnt;

   // Counters saturate and survive flush; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (r_stall_cnt != {STAT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush && (r_flush_cnt != {STAT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule
